// File: rtl/text_buffer_writer.sv
// Character-cell text buffer: cursor-driven write stream plus a 1-cycle registered renderer read port.
// Define TEXTBUF_SCROLL_EN for hardware scrolling (offset register, BLANK of the new bottom row).
module text_buffer_writer #(
    parameter int COLS_S = 80,
    parameter int ROWS_S = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sL,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [6:0] in_ascii,
    input  logic [5:0] in_colour,
    input  logic       in_hl,
    input  logic [6:0] cx,
    input  logic [5:0] cy,
    output logic [6:0] cascii,
    output logic [5:0] ccolour,
    output logic       chl,
    output logic [6:0] cur_x,
    output logic [5:0] cur_y,
    output logic       busy
);
    localparam int DEPTH = COLS_S * ROWS_S;
    localparam int AW = $clog2(DEPTH);
    localparam logic [13:0] BLANK_CELL = 14'h0020;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

`ifdef TEXTBUF_SCROLL_EN
    typedef enum logic [1:0] {IDLE, CLEAR, BLANK} state_t;
`else
    typedef enum logic [1:0] {IDLE, CLEAR} state_t;
`endif

    state_t        state_q, state_n;
    logic [AW-1:0] clr_q, clr_n;
    logic [6:0]    cur_x_q, cur_x_n;
    logic [5:0]    cur_y_q, cur_y_n;
    logic          sl_q;
    logic [5:0]    offset;
`ifdef TEXTBUF_SCROLL_EN
    logic [5:0]    off_q, off_n;
    logic [5:0]    brow_q, brow_n;
    logic [6:0]    bcnt_q, bcnt_n;
    assign offset = off_q;
`else
    assign offset = 6'd0;
`endif

    logic [6:0]    cols;
    logic [5:0]    rows;
    logic          we;
    logic [AW-1:0] waddr;
    logic [13:0]   wdata;
    logic          line_adv;

    // Grid geometry follows the registered mode so a mode change cannot glitch mid-operation.
    assign cols = sl_q ? 7'(COLS_S / 2) : 7'(COLS_S);
    assign rows = sl_q ? 6'(ROWS_S / 2) : 6'(ROWS_S);

    function automatic logic [5:0] row_wrap(input logic [5:0] a, input logic [5:0] b,
                                            input logic [5:0] n);
        logic [6:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, n}) s = s - {1'b0, n};
        return s[5:0];
    endfunction

    // Renderer read path
    logic          roob, oob_q;
    logic [5:0]    rrow;
    logic [AW-1:0] raddr;
    logic [13:0]   rd_q;
    logic [13:0]   mem [DEPTH];

    always_comb begin
        roob  = (cx >= cols) || (cy >= rows);
        rrow  = row_wrap(rows - 6'd1 - cy, offset, rows);
        raddr = AW'(rrow) * AW'(COLS_S) + AW'(cx);
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rd_q <= mem[raddr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) oob_q <= 1'b1;
        else       oob_q <= roob;
    end

    assign {chl, ccolour, cascii} = oob_q ? BLANK_CELL : rd_q;

    // Cursor write address
    logic [5:0]    wrow;
    logic [AW-1:0] cur_addr;
    assign wrow     = row_wrap(cur_y_q, offset, rows);
    assign cur_addr = AW'(wrow) * AW'(COLS_S) + AW'(cur_x_q);

    always_comb begin
        state_n  = state_q;
        clr_n    = clr_q;
        cur_x_n  = cur_x_q;
        cur_y_n  = cur_y_q;
        we       = 1'b0;
        waddr    = clr_q;
        wdata    = BLANK_CELL;
        line_adv = 1'b0;
`ifdef TEXTBUF_SCROLL_EN
        off_n    = off_q;
        brow_n   = brow_q;
        bcnt_n   = bcnt_q;
`endif
        case (state_q)
            CLEAR: begin
                we = 1'b1;
                if (clr_q == LAST_ADDR) begin
                    state_n = IDLE;
                    clr_n   = '0;
                    cur_x_n = '0;
                    cur_y_n = '0;
`ifdef TEXTBUF_SCROLL_EN
                    off_n   = '0;
`endif
                end else begin
                    clr_n = clr_q + 1'b1;
                end
            end
`ifdef TEXTBUF_SCROLL_EN
            BLANK: begin
                we    = 1'b1;
                waddr = AW'(brow_q) * AW'(COLS_S) + AW'(bcnt_q);
                if (bcnt_q == cols - 7'd1) begin
                    state_n = IDLE;
                    bcnt_n  = '0;
                end else begin
                    bcnt_n = bcnt_q + 7'd1;
                end
            end
`endif
            default: begin
                if (in_valid) begin
                    if (in_ascii >= 7'h20 && in_ascii <= 7'h7E) begin
                        we    = 1'b1;
                        waddr = cur_addr;
                        wdata = {in_hl, in_colour, in_ascii};
                        if (cur_x_q == cols - 7'd1) begin
                            cur_x_n  = '0;
                            line_adv = 1'b1;
                        end else begin
                            cur_x_n = cur_x_q + 7'd1;
                        end
                    end else begin
                        case (in_ascii)
                            7'h0A: begin cur_x_n = '0; line_adv = 1'b1; end
                            7'h0D: cur_x_n = '0;
                            7'h08: if (cur_x_q != '0) cur_x_n = cur_x_q - 7'd1;
                            7'h0C: begin state_n = CLEAR; clr_n = '0; end
                            default: ;
                        endcase
                    end
                    if (line_adv) begin
                        if (cur_y_q != rows - 6'd1) begin
                            cur_y_n = cur_y_q + 6'd1;
                        end else begin
`ifdef TEXTBUF_SCROLL_EN
                            // The old top physical row becomes the new bottom row.
                            off_n   = row_wrap(off_q, 6'd1, rows);
                            brow_n  = off_q;
                            bcnt_n  = '0;
                            state_n = BLANK;
`else
                            cur_y_n = '0;
`endif
                        end
                    end
                end
            end
        endcase
        // Mode change restarts the clear; at CLEAR address 0 the clear is already starting.
        if (sL != sl_q && !(state_q == CLEAR && clr_q == '0)) begin
            state_n = CLEAR;
            clr_n   = '0;
`ifdef TEXTBUF_SCROLL_EN
            off_n   = '0;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CLEAR;
            clr_q   <= '0;
            cur_x_q <= '0;
            cur_y_q <= '0;
            sl_q    <= 1'b0;
`ifdef TEXTBUF_SCROLL_EN
            off_q   <= '0;
            brow_q  <= '0;
            bcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_n;
            clr_q   <= clr_n;
            cur_x_q <= cur_x_n;
            cur_y_q <= cur_y_n;
            sl_q    <= sL;
`ifdef TEXTBUF_SCROLL_EN
            off_q   <= off_n;
            brow_q  <= brow_n;
            bcnt_q  <= bcnt_n;
`endif
        end
    end

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign cur_x    = cur_x_q;
    assign cur_y    = cur_y_q;

endmodule

// File: tb/tb_text_buffer_writer.sv
// Directed self-checking bench for text_buffer_writer; expectations follow the macro build in use.
module tb_text_buffer_writer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sL = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [6:0] in_ascii = 7'h0;
    logic [5:0] in_colour = 6'h0;
    logic       in_hl = 1'b0;
    logic [6:0] cx = 7'h0;
    logic [5:0] cy = 6'h0;
    logic [6:0] cascii;
    logic [5:0] ccolour;
    logic       chl;
    logic [6:0] cur_x;
    logic [5:0] cur_y;
    logic       busy;

    int checks = 0;
    int errors = 0;

    text_buffer_writer dut (
        .clk(clk), .reset(reset), .sL(sL),
        .in_valid(in_valid), .in_ready(in_ready), .in_ascii(in_ascii),
        .in_colour(in_colour), .in_hl(in_hl),
        .cx(cx), .cy(cy), .cascii(cascii), .ccolour(ccolour), .chl(chl),
        .cur_x(cur_x), .cur_y(cur_y), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_char(input logic [6:0] a, input logic [5:0] c, input logic h);
        int t;
        in_valid = 1'b1; in_ascii = a; in_colour = c; in_hl = h;
        t = 0;
        while (!in_ready && t < 10000) begin tick(); t++; end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout ascii=%h never accepted", a);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic read_cell(input logic [6:0] x, input logic [5:0] y);
        cx = x; cy = y;
        tick();
    endtask

    task automatic count_busy(output int n);
        n = 0;
        do begin tick(); n++; end while (busy && n < 10000);
    endtask

    task automatic test_reset();
        int n;
        repeat (3) tick();
        checks++;
        if ({in_ready, busy, cur_x, cur_y} !== {1'b0, 1'b1, 7'd0, 6'd0}) begin
            errors++; $display("FAIL reset_ctrl got rdy=%b busy=%b cur=(%0d,%0d) exp 0 1 (0,0)",
                                in_ready, busy, cur_x, cur_y);
        end
        checks++;
        if ({cascii, ccolour, chl} !== {7'h20, 6'h0, 1'b0}) begin
            errors++; $display("FAIL reset_cell got %h/%h/%b exp 20/00/0", cascii, ccolour, chl);
        end
        reset = 1'b0;
        count_busy(n);
        checks++;
        if (n != 4800) begin errors++; $display("FAIL reset_clear_len got %0d exp 4800", n); end
        checks++;
        if ({in_ready, cur_x, cur_y} !== {1'b1, 7'd0, 6'd0}) begin
            errors++; $display("FAIL post_clear got rdy=%b cur=(%0d,%0d) exp 1 (0,0)", in_ready, cur_x, cur_y);
        end
        read_cell(7'd5, 6'd59);
        checks++;
        if ({cascii, ccolour, chl} !== {7'h20, 6'h0, 1'b0}) begin
            errors++; $display("FAIL reset_read got %h/%h/%b exp 20/00/0", cascii, ccolour, chl);
        end
    endtask

    task automatic test_small_write();
        send_char(7'h41, 6'h3F, 1'b1);
        checks++;
        if (cur_x !== 7'd1) begin errors++; $display("FAIL write_adv got cur_x=%0d exp 1", cur_x); end
        read_cell(7'd0, 6'd59);
        checks++;
        if ({cascii, ccolour, chl} !== {7'h41, 6'h3F, 1'b1}) begin
            errors++; $display("FAIL write_A got %h/%h/%b exp 41/3f/1", cascii, ccolour, chl);
        end
        send_char(7'h08, 6'h0, 1'b0);
        send_char(7'h08, 6'h0, 1'b0);
        send_char(7'h01, 6'h0, 1'b0);
        checks++;
        if ({cur_x, cur_y} !== {7'd0, 6'd0}) begin
            errors++; $display("FAIL backspace_sat got cur=(%0d,%0d) exp (0,0)", cur_x, cur_y);
        end
        read_cell(7'd0, 6'd59);
        checks++;
        if (cascii !== 7'h41) begin errors++; $display("FAIL bs_nowrite got %h exp 41", cascii); end
        send_char(7'h0A, 6'h0, 1'b0);
        send_char(7'h5A, 6'h05, 1'b0);
        send_char(7'h0D, 6'h0, 1'b0);
        checks++;
        if ({cur_x, cur_y} !== {7'd0, 6'd1}) begin
            errors++; $display("FAIL lf_cr got cur=(%0d,%0d) exp (0,1)", cur_x, cur_y);
        end
        read_cell(7'd0, 6'd58);
        checks++;
        if ({cascii, ccolour, chl} !== {7'h5A, 6'h05, 1'b0}) begin
            errors++; $display("FAIL write_Z got %h/%h/%b exp 5a/05/0", cascii, ccolour, chl);
        end
        read_cell(7'd0, 6'd59);
        read_cell(7'd80, 6'd59);
        checks++;
        if ({cascii, ccolour, chl} !== {7'h20, 6'h0, 1'b0}) begin
            errors++; $display("FAIL oob_x got %h/%h/%b exp 20/00/0", cascii, ccolour, chl);
        end
        read_cell(7'd0, 6'd58);
        read_cell(7'd0, 6'd60);
        checks++;
        if ({cascii, ccolour, chl} !== {7'h20, 6'h0, 1'b0}) begin
            errors++; $display("FAIL oob_y got %h/%h/%b exp 20/00/0", cascii, ccolour, chl);
        end
    endtask

    task automatic test_clear_code();
        int n;
        send_char(7'h0A, 6'h0, 1'b0);
        send_char(7'h0A, 6'h0, 1'b0);
        for (int i = 0; i < 12; i++) send_char(7'h71, 6'h0A, 1'b1);
        checks++;
        if ({cur_x, cur_y} !== {7'd12, 6'd3}) begin
            errors++; $display("FAIL pre_clear_cur got (%0d,%0d) exp (12,3)", cur_x, cur_y);
        end
        send_char(7'h0C, 6'h0, 1'b0);
        count_busy(n);
        checks++;
        if (n != 4800) begin errors++; $display("FAIL ff_clear_len got %0d exp 4800", n); end
        checks++;
        if ({cur_x, cur_y} !== {7'd0, 6'd0}) begin
            errors++; $display("FAIL ff_cursor got (%0d,%0d) exp (0,0)", cur_x, cur_y);
        end
        read_cell(7'd0, 6'd59);
        checks++;
        if ({cascii, ccolour, chl} !== {7'h20, 6'h0, 1'b0}) begin
            errors++; $display("FAIL ff_cell_A got %h/%h/%b exp 20/00/0", cascii, ccolour, chl);
        end
        read_cell(7'd5, 6'd56);
        checks++;
        if ({cascii, ccolour, chl} !== {7'h20, 6'h0, 1'b0}) begin
            errors++; $display("FAIL ff_cell_q got %h/%h/%b exp 20/00/0", cascii, ccolour, chl);
        end
    endtask

    task automatic test_large();
        int n;
        sL = 1'b1;
        count_busy(n);
        checks++;
        if (n != 4801) begin errors++; $display("FAIL mode_clear_len got %0d exp 4801", n); end
        for (int i = 0; i < 40; i++) send_char(7'h42, 6'h01, 1'b0);
        checks++;
        if ({cur_x, cur_y} !== {7'd0, 6'd1}) begin
            errors++; $display("FAIL large_wrap got (%0d,%0d) exp (0,1)", cur_x, cur_y);
        end
        read_cell(7'd39, 6'd29);
        checks++;
        if ({cascii, ccolour, chl} !== {7'h42, 6'h01, 1'b0}) begin
            errors++; $display("FAIL large_B39 got %h/%h/%b exp 42/01/0", cascii, ccolour, chl);
        end
        read_cell(7'd40, 6'd0);
        checks++;
        if ({cascii, ccolour, chl} !== {7'h20, 6'h0, 1'b0}) begin
            errors++; $display("FAIL large_oob got %h/%h/%b exp 20/00/0", cascii, ccolour, chl);
        end
        read_cell(7'd0, 6'd28);
        checks++;
        if (cascii !== 7'h20) begin errors++; $display("FAIL large_row1 got %h exp 20", cascii); end
    endtask

    task automatic test_line_advance_bottom();
        int n;
        send_char(7'h0C, 6'h0, 1'b0);
        count_busy(n);
        send_char(7'h43, 6'h2A, 1'b1);
        send_char(7'h0A, 6'h0, 1'b0);
        send_char(7'h45, 6'h03, 1'b0);
        for (int i = 0; i < 28; i++) send_char(7'h0A, 6'h0, 1'b0);
        checks++;
        if ({cur_x, cur_y} !== {7'd0, 6'd29}) begin
            errors++; $display("FAIL bottom_row got (%0d,%0d) exp (0,29)", cur_x, cur_y);
        end
        send_char(7'h0A, 6'h0, 1'b0);
`ifdef TEXTBUF_SCROLL_EN
        count_busy(n);
        checks++;
        if (n != 40) begin errors++; $display("FAIL blank_len got %0d exp 40", n); end
        checks++;
        if ({cur_x, cur_y} !== {7'd0, 6'd29}) begin
            errors++; $display("FAIL scroll_cur got (%0d,%0d) exp (0,29)", cur_x, cur_y);
        end
        read_cell(7'd0, 6'd29);
        checks++;
        if ({cascii, ccolour, chl} !== {7'h45, 6'h03, 1'b0}) begin
            errors++; $display("FAIL scroll_E_top got %h/%h/%b exp 45/03/0", cascii, ccolour, chl);
        end
        read_cell(7'd0, 6'd0);
        checks++;
        if ({cascii, ccolour, chl} !== {7'h20, 6'h0, 1'b0}) begin
            errors++; $display("FAIL scroll_C_gone got %h/%h/%b exp 20/00/0", cascii, ccolour, chl);
        end
        send_char(7'h46, 6'h07, 1'b1);
        read_cell(7'd0, 6'd0);
        checks++;
        if ({cascii, ccolour, chl} !== {7'h46, 6'h07, 1'b1}) begin
            errors++; $display("FAIL scroll_F got %h/%h/%b exp 46/07/1", cascii, ccolour, chl);
        end
`else
        checks++;
        if ({busy, cur_x, cur_y} !== {1'b0, 7'd0, 6'd0}) begin
            errors++; $display("FAIL wrap_cur got busy=%b (%0d,%0d) exp 0 (0,0)", busy, cur_x, cur_y);
        end
        read_cell(7'd0, 6'd29);
        checks++;
        if ({cascii, ccolour, chl} !== {7'h43, 6'h2A, 1'b1}) begin
            errors++; $display("FAIL wrap_C_kept got %h/%h/%b exp 43/2a/1", cascii, ccolour, chl);
        end
        read_cell(7'd0, 6'd28);
        checks++;
        if (cascii !== 7'h45) begin errors++; $display("FAIL wrap_E_kept got %h exp 45", cascii); end
`endif
    endtask

    task automatic test_toggle_during_clear();
        int n;
        send_char(7'h0C, 6'h0, 1'b0);
        repeat (2000) tick();
        sL = 1'b0;
        in_valid = 1'b1; in_ascii = 7'h44; in_colour = 6'h11; in_hl = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!in_ready && n < 10000);
        checks++;
        if (n != 4801) begin errors++; $display("FAIL toggle_clear_len got %0d exp 4801", n); end
        checks++;
        if ({cur_x, cur_y} !== {7'd0, 6'd0}) begin
            errors++; $display("FAIL toggle_no_accept got (%0d,%0d) exp (0,0)", cur_x, cur_y);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if ({cur_x, cur_y} !== {7'd1, 6'd0}) begin
            errors++; $display("FAIL toggle_accept got (%0d,%0d) exp (1,0)", cur_x, cur_y);
        end
        read_cell(7'd0, 6'd59);
        checks++;
        if ({cascii, ccolour, chl} !== {7'h44, 6'h11, 1'b0}) begin
            errors++; $display("FAIL toggle_D got %h/%h/%b exp 44/11/0", cascii, ccolour, chl);
        end
    endtask

    initial begin
        test_reset();
        test_small_write();
        test_clear_code();
        test_large();
        test_line_advance_bottom();
        test_toggle_during_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
